pulse_conditioner: RTL and testbench
====================================

Name: pulse_conditioner

Overview:
Parametrised, multi-channel successor to the single-channel edge-to-pulse generator. It converts raw asynchronous inputs (board push-buttons, switches) into clean single-cycle pulses for the datapath's step/advance controls. Each channel has:
- a two-flop synchroniser, a debouncer and an edge detector with per-channel edge mode;
- optional hold-to-repeat.

It sits between the board I/O pins and the processor control FSM.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a level change (>=1; set from board clock at synthesis, e.g. 1_000_000 at 50 MHz).
- REPEAT_DELAY, 16: cycles from the initial press pulse to the first repeat pulse (>=2).
- REPEAT_PERIOD, 8: cycles between subsequent repeat pulses (>=2).
- Derived localparams: DB_W = clog2(DEBOUNCE_CYCLES+1) and RP_W = clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger_in  input  CHANNELS  raw asynchronous inputs, one bit per channel.
- edge_mode  input  2*CHANNELS  per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- repeat_en  input  CHANNELS  per-channel hold-to-repeat enable.
- level_out  output  CHANNELS  debounced level.
- pulse_out  output  CHANNELS  single-cycle pulses.
- any_pulse  output  1  registered OR of pulse_out (same cycle as pulse_out).

Behaviour:
Clocking and reset
- One clock: clk. Reset is synchronous and active-high on port reset.
- Reset clears all synchroniser flops, stable levels, debounce counters, repeat counters, level_out, pulse_out and any_pulse to 0. Outputs are 0 in the cycle after the reset edge.
- An input already held high when reset releases is treated as a fresh press: normal debounce, then a rising pulse.

Synchroniser
- Two flops per channel: sync1 <= trigger_in[i], then sync2 <= sync1.

Debounce (per channel)
- When sync2 != stable, the counter increments each cycle.
- When sync2 == stable, the counter clears to 0.
- When the counter reaches DEBOUNCE_CYCLES-1 and sync2 still differs, stable toggles and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES cycles (measured at sync2) leaves stable unchanged.
- level_out = stable, registered.

Latency
- Raw input first sampled high at edge k and held: level_out rises after edge k+1+DEBOUNCE_CYCLES, and pulse_out is high for exactly the cycle after edge k+2+DEBOUNCE_CYCLES.
- Release has the same latency.

Edge detection
- prev <= stable.
- rise = stable & ~prev; fall = ~stable & prev.
- pulse = (mode[0] & rise) | (mode[1] & fall), registered.
- Mode 00 suppresses all pulses, including repeats; level_out still tracks.
- Rise and fall on one channel can never occur in the same cycle.

Repeat FSM (per channel)
- States: IDLE, DELAY, REPEAT.
- IDLE -> DELAY on rise when repeat_en=1 and mode[0]=1; counter loads 0.
- DELAY: counter increments. When it reaches REPEAT_DELAY-1, emit a pulse and go to REPEAT with counter 0.
- REPEAT: counter increments. When it reaches REPEAT_PERIOD-1, emit a pulse and clear the counter.
- Return to IDLE with counter cleared whenever stable=0, repeat_en=0 or mode[0]=0. This takes priority over emitting a pulse in that cycle.
- Repeat pulses go through the same output register as edge pulses. Channel pulse_out is never high for two consecutive cycles, because REPEAT_PERIOD >= 2.

Multi-channel and runtime changes
- Channels are fully independent. Several pulse_out bits may be high in the same cycle. any_pulse is their OR.
- edge_mode and repeat_en are sampled every cycle. A change affects the next pulse decision only and never truncates or extends a pulse already registered.

Decomposition:
- Package pulse_conditioner_pkg holds:
  - edge-mode constants MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH;
  - the repeat-state typedef (IDLE, DELAY, REPEAT);
  - a clog2-style width helper.
- Sub-module pulse_channel holds one channel: synchroniser, debouncer, edge detector and repeat FSM, carrying the same parameters.
- The top level instantiates CHANNELS copies in a generate loop and registers any_pulse.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8, CHANNELS=4.
1. Clean press, ch0 mode 01, repeat_en=0. Raise trigger_in[0] at edge k and hold 40 cycles -> level_out[0]=1 after edge k+5; pulse_out[0] and any_pulse high only in the cycle after k+6; no further pulses; release gives no pulse.
2. Bounce rejection. trigger_in[1] toggles with 3-cycle high / 2-cycle low for 30 cycles, then ends low -> level_out[1] and pulse_out[1] stay 0 throughout.
3. Both-edge mode, ch2 mode 11. Press, hold 20 cycles, release -> exactly two pulses, spaced 20 cycles apart.
4. Auto-repeat, ch3 mode 01, repeat_en=1. Hold 50 cycles -> initial pulse at cycle P, then repeats at P+16, P+24, P+32, P+40, …. Release stops repeats within 1 cycle of level_out falling.
5. Reset mid-hold. Assert reset for 1 cycle during the DELAY phase with the input still high -> all outputs 0 next cycle; new rising pulse DEBOUNCE_CYCLES+3 cycles after reset release; repeat timing restarts from that pulse.
6. Simultaneous channels. Press ch0 and ch1 on the same edge, both mode 01 -> pulse_out=4'b0011 in one cycle, any_pulse=1 for that single cycle.

Source files
------------

// File: rtl/pulse_conditioner_pkg.sv
// Shared constants, repeat-FSM state encoding and width helpers for the
// pulse conditioner and its per-channel slice.
package pulse_conditioner_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef logic [1:0] rpt_state_t;

    localparam rpt_state_t RPT_IDLE   = 2'd0;
    localparam rpt_state_t RPT_DELAY  = 2'd1;
    localparam rpt_state_t RPT_REPEAT = 2'd2;

    // Ceiling log2 with a floor of one bit, usable in constant expressions.
    function automatic int unsigned clog2_w(input int unsigned value);
        int unsigned w;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(value)) begin
                w = w + 32'd1;
            end else begin
                w = w;
            end
        end
        if (w == 32'd0) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_conditioner_channel.sv
// One input channel: two-flop synchroniser, debouncer, edge detector and
// hold-to-repeat FSM, all feeding a single registered pulse output.
module pulse_channel
    import pulse_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger_in,
    input  logic [1:0] edge_mode,
    input  logic       repeat_en,
    output logic       level_out,
    output logic       pulse_out,
    output logic       pulse_next
);

    localparam int unsigned DB_W = clog2_w(DEBOUNCE_CYCLES + 32'd1);
    localparam int unsigned RP_W = clog2_w(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 32'd1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(32'd1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 32'd1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 32'd1);
    localparam logic [RP_W-1:0] RP_ONE  = RP_W'(32'd1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            prev_q;
    logic            pulse_q;
    logic            pulse_d;
    rpt_state_t      rpt_state_q;
    rpt_state_t      rpt_state_d;
    logic [RP_W-1:0] rpt_cnt_q;
    logic [RP_W-1:0] rpt_cnt_d;

    logic rise_s;
    logic fall_s;
    logic rpt_abort_s;
    logic rpt_fire_s;

    assign rise_s      = stable_q & ~prev_q;
    assign fall_s      = ~stable_q & prev_q;
    assign rpt_abort_s = ~stable_q | ~repeat_en | ~edge_mode[0];

    // Debouncer: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive samples that disagree with the current stable level.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = ~stable_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Repeat FSM: dropping the level, repeat_en or the rising mode bit
    // wins over any repeat pulse due in the same cycle.
    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_fire_s  = 1'b0;
        if (rpt_abort_s) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
        end else begin
            case (rpt_state_q)
                RPT_IDLE: begin
                    rpt_cnt_d = '0;
                    if (rise_s) begin
                        rpt_state_d = RPT_DELAY;
                    end else begin
                        rpt_state_d = RPT_IDLE;
                    end
                end
                RPT_DELAY: begin
                    if (rpt_cnt_q == RD_LAST) begin
                        rpt_fire_s  = 1'b1;
                        rpt_state_d = RPT_REPEAT;
                        rpt_cnt_d   = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RP_ONE;
                    end
                end
                RPT_REPEAT: begin
                    if (rpt_cnt_q == RP_LAST) begin
                        rpt_fire_s = 1'b1;
                        rpt_cnt_d  = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RP_ONE;
                    end
                end
                default: begin
                    rpt_state_d = RPT_IDLE;
                    rpt_cnt_d   = '0;
                end
            endcase
        end
    end

    // Edge pulses and repeat pulses share one output register.
    always_comb begin
        pulse_d = (edge_mode[0] & rise_s) | (edge_mode[1] & fall_s) | rpt_fire_s;
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            stable_q    <= 1'b0;
            db_cnt_q    <= '0;
            prev_q      <= 1'b0;
            pulse_q     <= 1'b0;
            rpt_state_q <= RPT_IDLE;
            rpt_cnt_q   <= '0;
        end else begin
            sync1_q     <= trigger_in;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            db_cnt_q    <= db_cnt_d;
            prev_q      <= stable_q;
            pulse_q     <= pulse_d;
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    assign level_out  = stable_q;
    assign pulse_out  = pulse_q;
    assign pulse_next = pulse_d;

endmodule

// File: rtl/pulse_conditioner.sv
// Multi-channel conditioner turning raw buttons/switches into clean
// single-cycle step pulses, plus a combined any_pulse flag.
module pulse_conditioner
    import pulse_conditioner_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   trigger_in,
    input  logic [2*CHANNELS-1:0] edge_mode,
    input  logic [CHANNELS-1:0]   repeat_en,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic                  any_pulse
);

    logic [CHANNELS-1:0] pulse_next_s;
    logic                any_pulse_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pulse_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .trigger_in (trigger_in[g]),
            .edge_mode  (edge_mode[2*g +: 2]),
            .repeat_en  (repeat_en[g]),
            .level_out  (level_out[g]),
            .pulse_out  (pulse_out[g]),
            .pulse_next (pulse_next_s[g])
        );
    end

    // OR the channels' next-state pulses so any_pulse lines up with pulse_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_pulse_q <= 1'b0;
        end else begin
            any_pulse_q <= |pulse_next_s;
        end
    end

    assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench: stimulus queues expected pulses with the cycle they must
// appear in; an independent monitor checks every pulse the DUT presents.
module tb_pulse_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] trigger_in;
    logic [7:0] edge_mode;
    logic [3:0] repeat_en;
    logic [3:0] level_out;
    logic [3:0] pulse_out;
    logic       any_pulse;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;

    pulse_conditioner #(
        .CHANNELS        (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (16),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trigger_in (trigger_in),
        .edge_mode  (edge_mode),
        .repeat_en  (repeat_en),
        .level_out  (level_out),
        .pulse_out  (pulse_out),
        .any_pulse  (any_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_exp(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endfunction

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every non-idle output must match the oldest queued expectation.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missed_pulse: got nothing, expected %b at cycle %0d", exp_q[0].vec, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (pulse_out != 4'b0000 || any_pulse) begin
            n_vec++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                if (pulse_out !== mon_e.vec || any_pulse !== 1'b1) begin
                    n_err++;
                    $display("FAIL pulse_value: got pulse_out=%b any=%b, expected pulse_out=%b any=1 (cycle %0d)",
                             pulse_out, any_pulse, mon_e.vec, cyc);
                end
            end else begin
                n_err++;
                $display("FAIL unexpected_pulse: got pulse_out=%b any=%b, expected 0000/0 (cycle %0d)",
                         pulse_out, any_pulse, cyc);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        trigger_in = 4'b0000;
        edge_mode  = 8'b01_11_11_01;
        repeat_en  = 4'b1000;
        idle(3);
        check("reset_level", level_out, 4'b0000);
        check("reset_pulse", pulse_out, 4'b0000);
        check("reset_any", {3'b000, any_pulse}, 4'b0000);
        reset = 1'b0;
        idle(3);

        // 1: clean press on ch0, rising only
        n = cyc;
        trigger_in[0] = 1'b1;
        push_exp(n + 7, 4'b0001);
        idle(5);
        check("t1_level_before", level_out & 4'b0001, 4'b0000);
        idle(1);
        check("t1_level_after", level_out & 4'b0001, 4'b0001);
        idle(34);
        trigger_in[0] = 1'b0;
        idle(5);
        check("t1_rel_before", level_out & 4'b0001, 4'b0001);
        idle(1);
        check("t1_rel_after", level_out & 4'b0001, 4'b0000);
        idle(10);

        // 2: ch1 bounce, 3 high / 2 low, never accepted
        for (int i = 0; i < 6; i++) begin
            trigger_in[1] = 1'b1;
            idle(3);
            trigger_in[1] = 1'b0;
            idle(2);
            check("t2_bounce_level", level_out & 4'b0010, 4'b0000);
        end
        idle(10);
        check("t2_final_level", level_out & 4'b0010, 4'b0000);

        // 3: ch2 both edges, pulses 20 cycles apart
        n = cyc;
        trigger_in[2] = 1'b1;
        push_exp(n + 7, 4'b0100);
        idle(20);
        trigger_in[2] = 1'b0;
        push_exp(n + 27, 4'b0100);
        idle(15);

        // 4: ch3 auto-repeat, held 50 cycles
        n = cyc;
        trigger_in[3] = 1'b1;
        push_exp(n + 7,  4'b1000);
        push_exp(n + 23, 4'b1000);
        push_exp(n + 31, 4'b1000);
        push_exp(n + 39, 4'b1000);
        push_exp(n + 47, 4'b1000);
        push_exp(n + 55, 4'b1000);
        idle(50);
        trigger_in[3] = 1'b0;
        idle(5);
        check("t4_rel_before", level_out & 4'b1000, 4'b1000);
        idle(1);
        check("t4_rel_after", level_out & 4'b1000, 4'b0000);
        idle(20);

        // 5: reset pulse during the DELAY phase with ch3 held
        n = cyc;
        trigger_in[3] = 1'b1;
        push_exp(n + 7, 4'b1000);
        idle(12);
        check("t5_level_held", level_out & 4'b1000, 4'b1000);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("t5_reset_level", level_out, 4'b0000);
        check("t5_reset_pulse", pulse_out, 4'b0000);
        check("t5_reset_any", {3'b000, any_pulse}, 4'b0000);
        push_exp(n + 20, 4'b1000);
        push_exp(n + 36, 4'b1000);
        push_exp(n + 44, 4'b1000);
        idle(32);
        trigger_in[3] = 1'b0;
        idle(20);
        check("t5_final_level", level_out & 4'b1000, 4'b0000);

        // 6: ch0 and ch1 together, both rising only
        edge_mode[3:2] = 2'b01;
        idle(2);
        n = cyc;
        trigger_in[1:0] = 2'b11;
        push_exp(n + 7, 4'b0011);
        idle(15);
        check("t6_level", level_out, 4'b0011);
        trigger_in[1:0] = 2'b00;
        idle(15);

        // 7: mode off on ch0 -- level tracks, no pulses
        edge_mode[1:0] = 2'b00;
        idle(2);
        trigger_in[0] = 1'b1;
        idle(6);
        check("t7_level_on", level_out & 4'b0001, 4'b0001);
        idle(10);
        trigger_in[0] = 1'b0;
        idle(10);
        check("t7_level_off", level_out & 4'b0001, 4'b0000);

        // 8: falling-only on ch0 -- pulse on release only
        edge_mode[1:0] = 2'b10;
        idle(2);
        trigger_in[0] = 1'b1;
        idle(12);
        n = cyc;
        trigger_in[0] = 1'b0;
        push_exp(n + 7, 4'b0001);
        idle(15);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
